// File: rtl/cic_pkg.sv
// Shared helpers for the CIC decimation path: bit-growth arithmetic and
// sign extension of narrow input samples onto the internal datapath width.
package cic_pkg;

    // Widest datapath the sign-extension helper can carry.
    localparam int CIC_MAX_W = 64;

    // Register growth of a CIC filter: STAGES * ceil(log2(R*M)) bits.
    function automatic int cic_growth(input int stages, input int r, input int m);
        return stages * $clog2(r * m);
    endfunction

    // Sign-extend the low src_w bits of value to the full CIC_MAX_W bits.
    function automatic logic [CIC_MAX_W-1:0] sign_extend(input logic [CIC_MAX_W-1:0] value,
                                                         input int src_w);
        int sh;
        sh = CIC_MAX_W - src_w;
        return $signed(value << sh) >>> sh;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One registered comb section: out <= in - in[n-M] at the decimated rate.
// The delay line and result only move when a token arrives, so gaps in the
// low-rate stream do not disturb the difference.
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int width = 28,
    parameter int M     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_valid,
    input  logic [width-1:0] src_data,
    output logic             res_valid,
    output logic [width-1:0] res_data
);

    logic [width-1:0] delay_reg [M];
    logic [width-1:0] data_reg;
    logic             valid_reg;

    // Difference against the oldest delayed sample, shift the delay line, pass the token on
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
            for (int i = 0; i < M; i++) begin
                delay_reg[i] <= '0;
            end
        end else begin
            valid_reg <= src_valid;
            if (src_valid) begin
                data_reg     <= src_data - delay_reg[M-1];
                delay_reg[0] <= src_data;
                for (int i = 1; i < M; i++) begin
                    delay_reg[i] <= delay_reg[i-1];
                end
            end
        end
    end

    assign res_valid = valid_reg;
    assign res_data  = data_reg;

endmodule

// File: rtl/cic_downsample.sv
// CIC decimator: STAGES integrators at the input rate, keep one of every R
// integrator outputs, then STAGES combs at the reduced rate. All arithmetic
// wraps modulo 2^(width_H+width_W); the combs cancel integrator overflow.
module cic_downsample
    import cic_pkg::*;
#(
    parameter int width_H = 12,
    parameter int width_W = 16,
    parameter int STAGES  = 3,
    parameter int R       = 8,
    parameter int M       = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       data_i_en,
    input  logic [width_W-1:0]         data_i,
    output logic                       data_o_en,
    output logic [width_H+width_W-1:0] data_o
);

    localparam int D  = width_H + width_W;
    localparam int PW = (R > 1) ? $clog2(R) : 1;

    // Integrator chain: index 0 is the extended input, index k is stage k.
    logic [D-1:0] int_data  [STAGES+1];
    logic         int_valid [STAGES+1];

    // Comb chain: index 0 is the decimator output, index j is comb stage j.
    logic [D-1:0] comb_data  [STAGES+1];
    logic         comb_valid [STAGES+1];

    logic [PW-1:0] phase_reg;
    logic [D-1:0]  dec_data_reg;
    logic          dec_valid_reg;

    assign int_data[0]  = D'(sign_extend(CIC_MAX_W'(data_i), width_W));
    assign int_valid[0] = data_i_en;

    generate
        for (genvar gi = 1; gi <= STAGES; gi++) begin : g_integ
            logic [D-1:0] acc_reg;
            logic         valid_reg;

            // Accumulate the upstream value whenever it carries a valid token
            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_reg   <= '0;
                    valid_reg <= 1'b0;
                end else begin
                    valid_reg <= int_valid[gi-1];
                    if (int_valid[gi-1]) begin
                        acc_reg <= acc_reg + int_data[gi-1];
                    end
                end
            end

            assign int_data[gi]  = acc_reg;
            assign int_valid[gi] = valid_reg;
        end
    endgenerate

    // Keep every R-th integrator output; the phase advances only on valid tokens
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg     <= '0;
            dec_data_reg  <= '0;
            dec_valid_reg <= 1'b0;
        end else begin
            dec_valid_reg <= 1'b0;
            if (int_valid[STAGES]) begin
                if (phase_reg == PW'(R - 1)) begin
                    phase_reg     <= '0;
                    dec_data_reg  <= int_data[STAGES];
                    dec_valid_reg <= 1'b1;
                end else begin
                    phase_reg <= phase_reg + PW'(1);
                end
            end
        end
    end

    assign comb_data[0]  = dec_data_reg;
    assign comb_valid[0] = dec_valid_reg;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_comb
            cic_comb_stage #(
                .width (D),
                .M     (M)
            ) u_comb (
                .clk       (clk),
                .rst       (rst),
                .src_valid (comb_valid[gi]),
                .src_data  (comb_data[gi]),
                .res_valid (comb_valid[gi+1]),
                .res_data  (comb_data[gi+1])
            );
        end
    endgenerate

    // The last comb's register is the output register: it holds between tokens.
    assign data_o    = comb_data[STAGES];
    assign data_o_en = comb_valid[STAGES];

endmodule

// File: tb/tb_cic_downsample.sv
// Self-checking bench for cic_downsample. Expected outputs come from a direct
// FIR view of the CIC: impulse response = (R*M boxcar)^STAGES, evaluated on
// the full-rate input at every R-th sample and truncated to the output width.
module tb_cic_downsample;

    localparam int WH   = 12;
    localparam int WW   = 16;
    localparam int S    = 3;
    localparam int RR   = 8;
    localparam int MM   = 1;
    localparam int D    = WH + WW;
    localparam int HLEN = S * (RR * MM - 1) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          data_i_en;
    logic [WW-1:0] data_i;
    logic          data_o_en;
    logic [D-1:0]  data_o;

    logic          en_b;
    logic [WW-1:0] din_b;
    logic          en_o_b;
    logic [D-1:0]  dout_b;

    always #5 clk = ~clk;

    cic_downsample #(.width_H(WH), .width_W(WW), .STAGES(S), .R(RR), .M(MM)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_i_en (data_i_en),
        .data_i    (data_i),
        .data_o_en (data_o_en),
        .data_o    (data_o)
    );

    cic_downsample #(.width_H(WH), .width_W(WW), .STAGES(1), .R(4), .M(1)) dut_imp (
        .clk       (clk),
        .rst       (rst),
        .data_i_en (en_b),
        .data_i    (din_b),
        .data_o_en (en_o_b),
        .data_o    (dout_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic signed [WW-1:0] stim_q[$];
    logic signed [D-1:0]  out_q[$];
    int                   out_cyc[$];
    int                   drive_cyc[$];
    logic signed [D-1:0]  imp_q[$];
    int                   imp_cyc[$];
    logic signed [D-1:0]  gapless_q[$];
    longint               h[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && data_o_en) begin
            out_q.push_back(data_o);
            out_cyc.push_back(cyc);
        end
        if (!rst && en_o_b) begin
            imp_q.push_back(dout_b);
            imp_cyc.push_back(cyc);
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Output n is the FIR response at full-rate input index n*R+R-1.
    function automatic logic signed [D-1:0] model_out(input int n);
        longint acc;
        int     idx;
        acc = 0;
        idx = n * RR + RR - 1;
        for (int k = 0; k < h.size(); k++) begin
            if (idx - k >= 0 && idx - k < stim_q.size()) begin
                acc += h[k] * longint'(stim_q[idx - k]);
            end
        end
        return D'(acc);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        en_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_i_en = 1'($urandom_range(1, 0));
            data_i    = WW'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("reset_data_o", longint'(data_o), 0);
            check("reset_data_o_en", longint'(data_o_en), 0);
        end
        rst       = 1'b0;
        data_i_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("release_data_o", longint'(data_o), 0);
        check("release_data_o_en", longint'(data_o_en), 0);
        out_q.delete();
        out_cyc.delete();
        drive_cyc.delete();
        $display("reset applied and released at cycle %0d", cyc);
    endtask

    // Apply stim_q on the main DUT; duty_pct < 100 inserts random idle cycles.
    task automatic drive(input int duty_pct, input bit drain);
        for (int i = 0; i < stim_q.size(); i++) begin
            if (duty_pct < 100) begin
                while ($urandom_range(99, 0) >= duty_pct) begin
                    data_i_en = 1'b0;
                    data_i    = WW'($urandom);
                    @(negedge clk);
                end
            end
            data_i_en = 1'b1;
            data_i    = stim_q[i];
            drive_cyc.push_back(cyc);
            @(negedge clk);
        end
        data_i_en = 1'b0;
        if (drain) repeat (2 * S + 4) @(negedge clk);
    endtask

    typedef struct {
        logic signed [WW-1:0] din;
        int                   nsamp;
        logic signed [D-1:0]  settled;
    } dc_vec_t;

    dc_vec_t dc_tbl[5];

    initial begin
        longint nh[$];
        int     nexp;

        rst = 1'b1; data_i_en = 1'b0; data_i = '0; en_b = 1'b0; din_b = '0;

        h.push_back(1);
        for (int s = 0; s < S; s++) begin
            nh.delete();
            for (int k = 0; k < h.size() + RR * MM - 1; k++) nh.push_back(0);
            for (int a = 0; a < h.size(); a++)
                for (int b = 0; b < RR * MM; b++) nh[a + b] += h[a];
            h = nh;
        end

        dc_tbl[0] = '{WW'(1000),   64,   D'(512000)};
        dc_tbl[1] = '{WW'(-32768), 2000, D'(-16777216)};
        dc_tbl[2] = '{WW'(32767),  64,   D'(16776704)};
        dc_tbl[3] = '{WW'(-1),     64,   D'(-512)};
        dc_tbl[4] = '{WW'(0),      40,   D'(0)};

        @(negedge clk);

        // Constant-input vectors: model match, settled DC value, pulse spacing
        for (int v = 0; v < 5; v++) begin
            do_reset();
            stim_q.delete();
            for (int i = 0; i < dc_tbl[v].nsamp; i++) stim_q.push_back(dc_tbl[v].din);
            drive(100, 1'b1);
            nexp = dc_tbl[v].nsamp / RR;
            check("dc_count", out_q.size(), nexp);
            if (out_q.size() > 0)
                check("dc_first_latency", out_cyc[0], drive_cyc[RR-1] + 1 + 2 * S);
            for (int n = 0; n < nexp && n < out_q.size(); n++) begin
                check("dc_model", out_q[n], model_out(n));
                if (n * RR + RR - 1 >= HLEN - 1)
                    check("dc_settled", out_q[n], dc_tbl[v].settled);
                if (n > 0)
                    check("dc_spacing", out_cyc[n] - out_cyc[n-1], RR);
            end
            $display("dc din=%0d samples=%0d outputs=%0d last=%0d", dc_tbl[v].din,
                     dc_tbl[v].nsamp, out_q.size(), (out_q.size() > 0) ? out_q[$] : 0);
        end

        // Random stream, gapless then with ~40% enable duty
        stim_q.delete();
        for (int i = 0; i < 200; i++) stim_q.push_back(WW'($urandom));
        do_reset();
        drive(100, 1'b1);
        check("rand_count", out_q.size(), 200 / RR);
        for (int n = 0; n < out_q.size(); n++) check("rand_model", out_q[n], model_out(n));
        if (out_q.size() > 0) check("hold_between_pulses", $signed(data_o), out_q[$]);
        gapless_q = out_q;
        $display("random gapless: %0d outputs", out_q.size());

        do_reset();
        drive(40, 1'b1);
        check("gap_count", out_q.size(), gapless_q.size());
        for (int n = 0; n < out_q.size() && n < gapless_q.size(); n++) begin
            check("gap_vs_gapless", out_q[n], gapless_q[n]);
            if (n > 0) check("gap_spacing_ge_R", (out_cyc[n] - out_cyc[n-1] >= RR) ? 1 : 0, 1);
        end
        $display("random gapped: %0d outputs", out_q.size());

        // Reset after the 5th sample of the second group, then 8 fresh samples
        stim_q.delete();
        for (int i = 0; i < 13; i++) stim_q.push_back(WW'($urandom));
        do_reset();
        drive(100, 1'b0);
        do_reset();
        repeat (10) @(negedge clk);
        check("midreset_no_spurious", out_q.size(), 0);
        stim_q.delete();
        for (int i = 0; i < 8; i++) stim_q.push_back(WW'($urandom));
        drive(100, 1'b1);
        check("midreset_count", out_q.size(), 1);
        if (out_q.size() > 0) check("midreset_value", out_q[0], model_out(0));
        $display("mid-group reset: %0d outputs after fresh group", out_q.size());

        // Impulse on the STAGES=1, R=4 instance
        begin
            int d3;
            d3 = 0;
            imp_q.delete();
            imp_cyc.delete();
            for (int i = 0; i < 16; i++) begin
                en_b  = 1'b1;
                din_b = (i == 0) ? WW'(1) : WW'(0);
                if (i == 3) d3 = cyc;
                @(negedge clk);
            end
            en_b = 1'b0;
            repeat (6) @(negedge clk);
            check("imp_count", imp_q.size(), 4);
            if (imp_q.size() > 0) check("imp_latency", imp_cyc[0], d3 + 3);
            for (int n = 0; n < imp_q.size() && n < 4; n++)
                check("imp_value", imp_q[n], (n == 0) ? 1 : 0);
            $display("impulse: %0d outputs, first=%0d", imp_q.size(),
                     (imp_q.size() > 0) ? imp_q[0] : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
